// File: rtl/mmc_spi_pkg.sv
// Shared types and constants for the MMC SPI byte shifter.
// Optional one-deep strobe queue is enabled with macro MMC_SPI_PENDING_EN.
package mmc_spi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOW,
      HIGH
   } state_e;

   localparam logic [7:0] IDLE_BYTE = 8'hFF;
   localparam int         DIV_W     = 8;

endpackage

// File: rtl/mmc_spi_shifter_if.sv
// Host-side handshake of the MMC SPI shifter: strobes, byte in/out and busy flag.
// The host drives the master modport; the shifter sits on the slave modport.
interface mmc_spi_shifter_if;

   logic       tx_strobe;
   logic       rx_strobe;
   logic [7:0] din;
   logic [7:0] dout;
   logic       transmit;

   modport master (output tx_strobe, output rx_strobe, output din,
                   input  dout,      input  transmit);

   modport slave  (input  tx_strobe, input  rx_strobe, input  din,
                   output dout,      output transmit);

endinterface

// File: rtl/mmc_spi_clkgen.sv
// Phase-tick divider: pulses tick once every CLK_DIV enabled cycles.
// clear or a tick restarts the count, so every SCK phase begins from zero.
module mmc_spi_clkgen
   import mmc_spi_pkg::*;
#(
   parameter int CLK_DIV = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;

   assign tick = enable && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear || tick) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mmc_spi_shifter.sv
// SPI mode-0 byte shifter for MMC cards: MSB first, read-ahead dout.
// Define MMC_SPI_PENDING_EN to queue one strobe that arrives mid-transfer.
module mmc_spi_shifter
   import mmc_spi_pkg::*;
#(
   parameter int CLK_DIV = 1
) (
   input  logic               clk,
   input  logic               reset,
   mmc_spi_shifter_if.slave   host,
   output logic               spi_clk,
   output logic               spi_do,
   input  logic               spi_di
);

   state_e     state_q, state_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] rx_q, rx_d;
   logic [7:0] dout_q, dout_d;
   logic [2:0] bit_q, bit_d;

   logic       tick;
   logic       strobe;
   logic [7:0] strobe_data;
   logic       last_tick;
   logic       pend_take;
   logic [7:0] pend_load;

   // tx_strobe wins when both strobes arrive together
   assign strobe      = host.tx_strobe || host.rx_strobe;
   assign strobe_data = host.tx_strobe ? host.din : IDLE_BYTE;
   assign last_tick   = (state_q == HIGH) && tick && (bit_q == 3'd7);

   mmc_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .clk    (clk),
      .reset  (reset),
      .enable (state_q != IDLE),
      .clear  (state_q == IDLE),
      .tick   (tick)
   );

`ifdef MMC_SPI_PENDING_EN
   logic       pend_valid_q, pend_valid_d;
   logic [7:0] pend_data_q, pend_data_d;

   // A strobe landing on the final tick is newer than the slot, so it is taken directly
   assign pend_take = last_tick && (pend_valid_q || strobe);
   assign pend_load = strobe ? strobe_data : pend_data_q;

   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_data_d  = pend_data_q;
      if (pend_take) begin
         pend_valid_d = 1'b0;
      end else if ((state_q != IDLE) && strobe) begin
         pend_valid_d = 1'b1;
         pend_data_d  = strobe_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_valid_q <= 1'b0;
         pend_data_q  <= IDLE_BYTE;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_data_q  <= pend_data_d;
      end
   end
`else
   assign pend_take = 1'b0;
   assign pend_load = IDLE_BYTE;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         tx_q    <= IDLE_BYTE;
         rx_q    <= '0;
         dout_q  <= IDLE_BYTE;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         dout_q  <= dout_d;
         bit_q   <= bit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (strobe) state_d = LOW;
         LOW:     if (tick) state_d = HIGH;
         HIGH:    if (tick) state_d = (bit_q == 3'd7 && !pend_take) ? IDLE : LOW;
         default: state_d = IDLE;
      endcase
   end

   // Sample MISO entering the high phase, advance MOSI leaving it
   always_comb begin
      tx_d   = tx_q;
      rx_d   = rx_q;
      dout_d = dout_q;
      bit_d  = bit_q;
      case (state_q)
         IDLE: begin
            if (strobe) tx_d = strobe_data;
         end
         LOW: begin
            if (tick) rx_d = {rx_q[6:0], spi_di};
         end
         HIGH: begin
            if (tick) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  dout_d = rx_q;
                  tx_d   = pend_take ? pend_load : IDLE_BYTE;
               end else begin
                  tx_d = {tx_q[6:0], 1'b1};
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      spi_clk       = (state_q == HIGH);
      spi_do        = (state_q == IDLE) ? 1'b1 : tx_q[7];
      host.transmit = (state_q != IDLE);
      host.dout     = dout_q;
   end

endmodule

// File: tb/tb_mmc_spi_shifter.sv
// Directed self-checking bench for mmc_spi_shifter at CLK_DIV=1 and CLK_DIV=4.
// Pending-slot expectations follow MMC_SPI_PENDING_EN.
module tb_mmc_spi_shifter;

   logic clk = 1'b0;
   logic reset;
   logic sel;
   logic loopback;
   logic miso;

   logic spi_clk1, spi_do1, spi_di1;
   logic spi_clk4, spi_do4, spi_di4;

   int checks   = 0;
   int failures = 0;

   logic [15:0] got_mosi;
   int          got_high;
   int          got_min;
   int          got_max;
   bit          got_changed;

   mmc_spi_shifter_if bus1 ();
   mmc_spi_shifter_if bus4 ();

   mmc_spi_shifter #(.CLK_DIV(1)) dut1 (
      .clk     (clk),
      .reset   (reset),
      .host    (bus1),
      .spi_clk (spi_clk1),
      .spi_do  (spi_do1),
      .spi_di  (spi_di1)
   );

   mmc_spi_shifter #(.CLK_DIV(4)) dut4 (
      .clk     (clk),
      .reset   (reset),
      .host    (bus4),
      .spi_clk (spi_clk4),
      .spi_do  (spi_do4),
      .spi_di  (spi_di4)
   );

   assign spi_di1 = loopback ? spi_do1 : miso;
   assign spi_di4 = loopback ? spi_do4 : miso;

   wire       m_spi_clk  = sel ? spi_clk4      : spi_clk1;
   wire       m_spi_do   = sel ? spi_do4       : spi_do1;
   wire       m_transmit = sel ? bus4.transmit : bus1.transmit;
   wire [7:0] m_dout     = sel ? bus4.dout     : bus1.dout;

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive_strobes(input bit t, input bit r, input logic [7:0] d);
      if (sel) begin
         bus4.tx_strobe = t;
         bus4.rx_strobe = r;
         bus4.din       = d;
      end else begin
         bus1.tx_strobe = t;
         bus1.rx_strobe = r;
         bus1.din       = d;
      end
   endtask

   task automatic clear_strobes();
      bus1.tx_strobe = 1'b0;
      bus1.rx_strobe = 1'b0;
      bus4.tx_strobe = 1'b0;
      bus4.rx_strobe = 1'b0;
   endtask

   // Called at a falling edge; runs one transfer and records what the pins did
   task automatic apply_stimulus(input bit sel_i, input bit use_tx, input bit use_rx,
                                 input logic [7:0] d, input logic [7:0] pat, input bit lb,
                                 input int inj_at, input logic [7:0] inj_d, input int rst_at);
      int          idx;
      int          nrise;
      int          run;
      logic        prev_clk;
      logic [7:0]  start_dout;
      sel      = sel_i;
      loopback = lb;
      drive_strobes(use_tx, use_rx, d);
      @(negedge clk);
      clear_strobes();
      idx         = 0;
      nrise       = 0;
      run         = 0;
      prev_clk    = 1'b0;
      got_mosi    = '0;
      got_min     = 1000;
      got_max     = 0;
      got_changed = 1'b0;
      start_dout  = m_dout;
      while (m_transmit && idx < 200) begin
         if (inj_at >= 0 && idx == inj_at) drive_strobes(1'b1, 1'b0, inj_d);
         else clear_strobes();
         if (idx == rst_at) reset = 1'b1;
         if (idx == 0) run = 1;
         else if (m_spi_clk == prev_clk) run++;
         else begin
            if (run < got_min) got_min = run;
            if (run > got_max) got_max = run;
            run = 1;
         end
         if (m_spi_clk && !prev_clk) begin
            got_mosi = {got_mosi[14:0], m_spi_do};
            nrise++;
         end
         if (!m_spi_clk) miso = pat[7 - (nrise % 8)];
         if (m_dout !== start_dout) got_changed = 1'b1;
         prev_clk = m_spi_clk;
         idx++;
         @(negedge clk);
      end
      if (run < got_min) got_min = run;
      if (run > got_max) got_max = run;
      clear_strobes();
      got_high = idx;
   endtask

   initial begin
      reset    = 1'b1;
      sel      = 1'b0;
      loopback = 1'b0;
      miso     = 1'b0;
      bus1.din = 8'h00;
      bus4.din = 8'h00;
      clear_strobes();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      check_output("rst_dout",     m_dout,        8'hFF);
      check_output("rst_transmit", m_transmit,    1'b0);
      check_output("rst_spi_clk",  m_spi_clk,     1'b0);
      check_output("rst_spi_do",   m_spi_do,      1'b1);
      check_output("rst_dout4",    bus4.dout,     8'hFF);

      // tx A5 with MISO looped back to MOSI
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b1, -1, 8'h00, -1);
      check_output("a5_mosi",      got_mosi[7:0], 8'hA5);
      check_output("a5_high",      got_high,      16);
      check_output("a5_dout",      m_dout,        8'hA5);
      check_output("a5_stable",    got_changed,   1'b0);
      check_output("a5_run_min",   got_min,       1);
      check_output("a5_run_max",   got_max,       1);
      check_output("a5_end_clk",   m_spi_clk,     1'b0);
      check_output("a5_end_do",    m_spi_do,      1'b1);

      // read-ahead straight after IDLE entry, card returns 3C
      apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h3C, 1'b0, -1, 8'h00, -1);
      check_output("rx_mosi",      got_mosi[7:0], 8'hFF);
      check_output("rx_high",      got_high,      16);
      check_output("rx_prev_dout", got_changed,   1'b0);
      check_output("rx_dout",      m_dout,        8'h3C);

      // both strobes together: din wins
      apply_stimulus(1'b0, 1'b1, 1'b1, 8'h12, 8'h00, 1'b1, -1, 8'h00, -1);
      check_output("both_mosi",    got_mosi[7:0], 8'h12);
      check_output("both_dout",    m_dout,        8'h12);

      // CLK_DIV=4 instance
      apply_stimulus(1'b1, 1'b1, 1'b0, 8'hC3, 8'h00, 1'b1, -1, 8'h00, -1);
      check_output("div4_high",    got_high,      64);
      check_output("div4_run_min", got_min,       4);
      check_output("div4_run_max", got_max,       4);
      check_output("div4_mosi",    got_mosi[7:0], 8'hC3);
      check_output("div4_dout",    m_dout,        8'hC3);

      // reset in the fifth cycle of a transfer
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'h5A, 8'h00, 1'b1, -1, 8'h00, 4);
      check_output("rst_mid_high", got_high,      5);
      check_output("rst_mid_dout", m_dout,        8'hFF);
      check_output("rst_mid_clk",  m_spi_clk,     1'b0);
      check_output("rst_mid_do",   m_spi_do,      1'b1);
      check_output("rst_mid_tx",   m_transmit,    1'b0);
      reset = 1'b0;
      @(negedge clk);

      // strobe 01 mid-transfer of 81
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'h81, 8'h00, 1'b1, 3, 8'h01, -1);
`ifdef MMC_SPI_PENDING_EN
      check_output("pend_high",    got_high,      32);
      check_output("pend_mosi",    got_mosi,      16'h8101);
      check_output("pend_dout",    m_dout,        8'h01);
`else
      check_output("pend_high",    got_high,      16);
      check_output("pend_mosi",    got_mosi,      16'h0081);
      check_output("pend_dout",    m_dout,        8'h81);
`endif
      repeat (3) @(negedge clk);
      check_output("pend_after",   m_transmit,    1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
